// File: rtl/seg_scan_capture.sv
// Receive side of a scanned 4-digit 7-segment bus: synchronizes the pins, waits for a
// stable select+pattern, captures it per digit, decodes it to hex, and watches for scan loss.
module seg_scan_capture #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  Dig_In,
  input  logic [7:0]  Seg_In,
  output logic [31:0] Raw,
  output logic [15:0] Code,
  output logic [3:0]  Code_Valid,
  output logic        Frame_Done,
  output logic        Multi_Sel,
  output logic        Scan_Lost
);

  localparam logic [7:0]  STB_MAX = 8'(STABLE_CYC);
  localparam logic [7:0]  STB_PRE = 8'(STABLE_CYC - 1);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYC);

  // Returns {valid, hex} for an active-high gfedcba pattern.
  function automatic logic [4:0] f_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [3:0]  r_dig_s1, r_dig_s2;
  logic [7:0]  r_seg_s1, r_seg_s2;
  logic [11:0] r_prev;
  logic [7:0]  r_stb_cnt;
  logic [15:0] r_to_cnt;
  logic [3:0]  r_mask;
  logic [31:0] r_raw;
  logic [15:0] r_code;
  logic [3:0]  r_cv;
  logic        r_frame_done, r_multi_sel, r_scan_lost;

  logic [3:0]  w_sel, w_cap_mask, w_mask_next;
  logic [7:0]  w_seg, w_stb_next;
  logic [2:0]  w_sel_cnt;
  logic        w_sel_valid, w_sel_multi, w_run, w_hit, w_cap, w_multi_hit;
  logic [15:0] w_to_next;
  logic [4:0]  w_dec;

  // Stability, capture, frame-mask and timeout next-state logic.
  always_comb begin
    w_sel       = ~r_dig_s2;
    w_seg       = ~r_seg_s2;
    w_sel_cnt   = {2'b00, w_sel[0]} + {2'b00, w_sel[1]} + {2'b00, w_sel[2]} + {2'b00, w_sel[3]};
    w_sel_valid = (w_sel_cnt == 3'd1);
    w_sel_multi = (w_sel_cnt >= 3'd2);
    // A multi-select run shares the stability counter; validity cannot change within a run.
    w_run       = ({w_sel, w_seg} == r_prev) && (w_sel_valid || w_sel_multi);
    w_hit       = w_run && (r_stb_cnt == STB_PRE);
    w_cap       = w_hit && w_sel_valid;
    w_multi_hit = w_hit && w_sel_multi;
    w_dec       = f_decode(w_seg[6:0]);
    w_cap_mask  = 4'b0000;
    w_stb_next  = 8'd0;
    w_to_next   = 16'd0;
    if (w_cap) begin
      w_cap_mask = w_sel;
    end else begin
      w_cap_mask = 4'b0000;
    end
    if (w_run && (r_stb_cnt != STB_MAX)) begin
      w_stb_next = r_stb_cnt + 8'd1;
    end else if (w_run) begin
      w_stb_next = r_stb_cnt;
    end else begin
      w_stb_next = 8'd0;
    end
    if (w_sel_valid) begin
      w_to_next = 16'd0;
    end else if (r_to_cnt != TO_MAX) begin
      w_to_next = r_to_cnt + 16'd1;
    end else begin
      w_to_next = r_to_cnt;
    end
    // A full mask is held for exactly the Frame_Done cycle; a capture then starts the new mask.
    if (r_mask == 4'hF) begin
      w_mask_next = w_cap_mask;
    end else begin
      w_mask_next = r_mask | w_cap_mask;
    end
  end

  // Two-stage synchronizer; reset to the idle (all-high) pin level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dig_s1 <= 4'hF;
      r_dig_s2 <= 4'hF;
      r_seg_s1 <= 8'hFF;
      r_seg_s2 <= 8'hFF;
    end else begin
      r_dig_s1 <= Dig_In;
      r_dig_s2 <= r_dig_s1;
      r_seg_s1 <= Seg_In;
      r_seg_s2 <= r_seg_s1;
    end
  end

  // Capture state, per-digit data and status pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_prev       <= 12'h000;
      r_stb_cnt    <= 8'd0;
      r_to_cnt     <= 16'd0;
      r_mask       <= 4'h0;
      r_raw        <= 32'h0000_0000;
      r_code       <= 16'h0000;
      r_cv         <= 4'h0;
      r_frame_done <= 1'b0;
      r_multi_sel  <= 1'b0;
      r_scan_lost  <= 1'b0;
    end else begin
      r_prev       <= {w_sel, w_seg};
      r_stb_cnt    <= w_stb_next;
      r_to_cnt     <= w_to_next;
      r_mask       <= w_mask_next;
      r_frame_done <= (w_mask_next == 4'hF);
      r_multi_sel  <= w_multi_hit;
      r_scan_lost  <= (w_to_next == TO_MAX);
      for (int k = 0; k < 4; k++) begin
        if (w_cap_mask[k]) begin
          r_raw[8*k +: 8]  <= w_seg;
          r_code[4*k +: 4] <= w_dec[3:0];
          r_cv[k]          <= w_dec[4];
        end
      end
    end
  end

  assign Raw        = r_raw;
  assign Code       = r_code;
  assign Code_Valid = r_cv;
  assign Frame_Done = r_frame_done;
  assign Multi_Sel  = r_multi_sel;
  assign Scan_Lost  = r_scan_lost;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus randomized scan holds
// compared against a digit-level model (capture when a one-hot select holds > STABLE_CYC samples).
module tb_seg_scan_capture;

  localparam int S = 4;
  localparam int T = 16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  Dig_In = 4'hF;
  logic [7:0]  Seg_In = 8'hFF;
  logic [31:0] Raw;
  logic [15:0] Code;
  logic [3:0]  Code_Valid;
  logic        Frame_Done, Multi_Sel, Scan_Lost;

  seg_scan_capture #(.STABLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Dig_In(Dig_In), .Seg_In(Seg_In),
    .Raw(Raw), .Code(Code), .Code_Valid(Code_Valid),
    .Frame_Done(Frame_Done), .Multi_Sel(Multi_Sel), .Scan_Lost(Scan_Lost)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0;
  int n_frame = 0, n_multi = 0;
  int exp_frames = 0, exp_multi = 0;
  logic [7:0] m_raw [4];
  logic [3:0] m_mask = 4'h0;
  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] loop_pat [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};

  // Pulse counters sampled away from the active edge.
  always @(negedge Clk) begin
    if (Frame_Done === 1'b1) n_frame++;
    if (Multi_Sel === 1'b1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [7:0] r);
    for (int i = 0; i < 16; i++) begin
      if (hex_tab[i] == {1'b0, r[6:0]}) return {1'b1, 4'(i)};
    end
    return 5'd0;
  endfunction

  task automatic check_state(input string tag);
    logic [31:0] er;
    logic [15:0] ec;
    logic [3:0]  ev;
    logic [4:0]  d;
    for (int k = 0; k < 4; k++) begin
      d = ref_dec(m_raw[k]);
      er[8*k +: 8] = m_raw[k];
      ec[4*k +: 4] = d[3:0];
      ev[k] = d[4];
    end
    check({tag, ".raw"}, Raw, er);
    check({tag, ".code"}, {16'h0, Code}, {16'h0, ec});
    check({tag, ".cvalid"}, {28'h0, Code_Valid}, {28'h0, ev});
    check({tag, ".frames"}, n_frame, exp_frames);
    check({tag, ".multi"}, n_multi, exp_multi);
  endtask

  // Called #1 after a posedge: drive pattern for n edges, then blank for gap edges (gap 0 keeps pins).
  task automatic hold(input logic [3:0] sel, input logic [7:0] pat, input int n, input int gap);
    int k;
    Dig_In = ~sel;
    Seg_In = ~pat;
    repeat (n) @(posedge Clk);
    #1;
    if (gap > 0) begin
      Dig_In = 4'hF;
      repeat (gap) @(posedge Clk);
      #1;
    end
    if (n >= S + 1) begin
      if ($countones(sel) == 1) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) k = i;
        m_raw[k] = pat;
        m_mask = m_mask | sel;
        if (m_mask == 4'hF) begin
          exp_frames++;
          m_mask = 4'h0;
        end
      end else if ($countones(sel) >= 2) begin
        exp_multi++;
      end
    end
  endtask

  initial begin
    logic [3:0] rs;
    logic [7:0] rp;
    for (int k = 0; k < 4; k++) m_raw[k] = 8'h00;

    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    check("rst.raw", Raw, 32'h0);
    check("rst.code", {16'h0, Code}, 32'h0);
    check("rst.cvalid", {28'h0, Code_Valid}, 32'h0);
    check("rst.fdone", {31'h0, Frame_Done}, 32'h0);
    check("rst.multi", {31'h0, Multi_Sel}, 32'h0);
    check("rst.lost", {31'h0, Scan_Lost}, 32'h0);

    hold(4'b0010, 8'h5B, 3, 0);
    hold(4'b0010, 8'h4F, 3, 4);
    check("short.d2", {24'h0, Raw[15:8]}, 32'h0);
    check_state("short");

    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 4; k++) hold(4'(1 << k), loop_pat[k], 8, 2);
    repeat (2) @(posedge Clk);
    #1;
    check("loop.code", {16'h0, Code}, 32'h3210);
    check("loop.cvalid", {28'h0, Code_Valid}, 32'hF);
    check("loop.frames2", n_frame, 2);
    check_state("loop");

    hold(4'b0001, 8'hC9, 8, 4);
    check("bad.raw0", {24'h0, Raw[7:0]}, 32'hC9);
    check("bad.code0", {28'h0, Code[3:0]}, 32'h0);
    check("bad.cv0", {31'h0, Code_Valid[0]}, 32'h0);
    check_state("badpat");

    hold(4'b0101, 8'h3F, 10, 4);
    check("multi.once", n_multi, 1);
    check_state("multi");

    hold(4'b1000, 8'h7F, S, 4);
    check_state("edge.s");
    hold(4'b1000, 8'h6F, S + 1, 4);
    check_state("edge.s1");

    repeat (5) @(posedge Clk);
    #1;
    check("idle.early", {31'h0, Scan_Lost}, 32'h0);
    repeat (12) @(posedge Clk);
    #1;
    check("idle.lost", {31'h0, Scan_Lost}, 32'h1);
    check_state("idle");
    hold(4'b0001, 8'h3F, 3, 1);
    check("resume.lost", {31'h0, Scan_Lost}, 32'h0);
    check_state("resume");

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3, 0) != 0) begin
        rs = 4'(1 << $urandom_range(3, 0));
      end else begin
        rs = 4'($urandom_range(15, 3));
        while ($countones(rs) < 2) rs = 4'($urandom_range(15, 3));
      end
      if ($urandom_range(1, 0) == 1) begin
        rp = hex_tab[$urandom_range(15, 0)] | {$urandom_range(1, 0) == 1, 7'h00};
      end else begin
        rp = 8'($urandom);
      end
      hold(rs, rp, $urandom_range(8, 1), $urandom_range(5, 3));
      check_state($sformatf("rnd%0d", it));
    end

    hold(4'b0001, 8'h66, 8, 3);
    hold(4'b0010, 8'h6D, 8, 3);
    Reset_n = 1'b0;
    #1;
    check("mrst.raw", Raw, 32'h0);
    check("mrst.code", {16'h0, Code}, 32'h0);
    check("mrst.cvalid", {28'h0, Code_Valid}, 32'h0);
    check("mrst.fdone", {31'h0, Frame_Done}, 32'h0);
    check("mrst.lost", {31'h0, Scan_Lost}, 32'h0);
    for (int k = 0; k < 4; k++) m_raw[k] = 8'h00;
    m_mask = 4'h0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    hold(4'b0100, 8'h7D, 8, 3);
    hold(4'b1000, 8'h07, 8, 3);
    check_state("post.half");
    hold(4'b0001, 8'h77, 8, 3);
    hold(4'b0010, 8'h7C, 8, 3);
    check_state("post.full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
